mem_resp_port: RTL

- Memory-side responder for the core's data/instruction bus: accepts one word request at a time from an initiator (the processor's fetch or load/store path) and returns a response after a programmable number of wait states.
- Owns a DEPTH-word, byte-lane-writable storage array.
- Uses a valid/ready request channel and a valid/ready response channel, so initiators can be built against realistic memory latency instead of the single-cycle RAM.

---
 rtl/mem_resp_port.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_resp_port.sv
// Word-wide memory responder with valid/ready request and response channels.
// A request is accepted in IDLE, then the response is presented LATENCY cycles later.
module mem_resp_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rstL,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_wenL,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [31:0]        r_mem [DEPTH];
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_err;
    logic               r_wr;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    logic [ADDR_WIDTH-3:0] w_word;
    logic [IDX_W-1:0]      w_req_idx;
    logic                  w_req_err;
    logic                  w_req_wr;
    logic                  w_accept;
    logic                  w_mem_we;
    logic                  w_load_rsp;
    logic                  w_src_err;
    logic                  w_src_wr;
    logic [IDX_W-1:0]      w_src_idx;
    logic [31:0]           w_rsp_data;

    assign w_word    = req_addr[ADDR_WIDTH-1:2];
    assign w_req_idx = w_word[IDX_W-1:0];
    assign w_req_err = (req_addr[1:0] != 2'b00) || (int'(w_word) >= DEPTH);
    assign w_req_wr  = (req_wenL != 4'hF);
    assign w_accept  = (r_state == IDLE) && r_req_ready && req_valid;
    assign w_mem_we  = w_accept && !w_req_err && w_req_wr;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY > 1) w_next_state = BUSY;
                    else             w_next_state = RESP;
                end
            end
            BUSY: begin
                if (r_cnt <= CNT_W'(1)) w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // With LATENCY==1 the response is loaded on the accept edge, straight from the request.
    always_comb begin
        w_src_err = r_err;
        w_src_wr  = r_wr;
        w_src_idx = r_idx;
        if (r_state == IDLE) begin
            w_src_err = w_req_err;
            w_src_wr  = w_req_wr;
            w_src_idx = w_req_idx;
        end
        w_load_rsp = (w_next_state == RESP) && (r_state != RESP);
        w_rsp_data = (w_src_err || w_src_wr) ? 32'h0 : r_mem[w_src_idx];
    end

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
        end else if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!req_wenL[b]) r_mem[w_req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_wr        <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_next_state == IDLE);
            r_rsp_valid <= (w_next_state == RESP);
            if (w_accept) begin
                r_idx <= w_req_idx;
                r_err <= w_req_err;
                r_wr  <= w_req_wr;
                r_cnt <= CNT_LOAD;
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_load_rsp) begin
                r_rsp_rdata <= w_rsp_data;
                r_rsp_err   <= w_src_err;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_rdata <= 32'h0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
